// File: rtl/qstate_pkg.sv
// Shared amplitude-format constants, basis encoding and FSM states for the
// 2-qubit amplitude estimator.
package qstate_pkg;

  localparam int AMP_W       = 16;
  localparam int AMP_FRAC    = 15;
  localparam int AMP_ONE_SAT = 32767;

  localparam logic [1:0] BASIS_00 = 2'b00;
  localparam logic [1:0] BASIS_01 = 2'b01;
  localparam logic [1:0] BASIS_10 = 2'b10;
  localparam logic [1:0] BASIS_11 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SQRT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A root of exactly 1.0 (32768) cannot be represented in Q1.15.
  function automatic logic [AMP_W-1:0] sat_amp(input logic [AMP_W:0] v);
    return (v > (AMP_W+1)'(AMP_ONE_SAT)) ? AMP_W'(AMP_ONE_SAT) : v[AMP_W-1:0];
  endfunction

endpackage

// File: rtl/isqrt_serial.sv
// Restoring bit-serial integer square root: 31-bit radicand, 16-bit root,
// one root bit per cycle. Root and remainder are valid while o_valid is high.
module isqrt_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [30:0] i_radicand,
  output logic        o_busy,
  output logic        o_valid,
  output logic [15:0] o_root,
  output logic [16:0] o_remainder
);

  logic [31:0] r_x;
  logic [16:0] r_rem;
  logic [14:0] r_root;
  logic [3:0]  r_iter;
  logic        r_busy;

  logic [18:0] w_rem_sh;
  logic [18:0] w_trial;
  logic        w_ge;
  logic [15:0] w_root_nxt;
  logic [16:0] w_rem_nxt;

  assign w_rem_sh   = {r_rem, r_x[31:30]};
  assign w_trial    = {2'b00, r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_root_nxt = {r_root, w_ge};
  // The true difference always fits in 17 bits, so modulo-2^17 arithmetic is exact.
  assign w_rem_nxt  = w_ge ? (w_rem_sh[16:0] - w_trial[16:0]) : w_rem_sh[16:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
    end else if (i_load && !r_busy) begin
      r_x    <= {1'b0, i_radicand};
      r_rem  <= '0;
      r_root <= '0;
      r_iter <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_x    <= {r_x[29:0], 2'b00};
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt[14:0];
      r_iter <= r_iter + 4'd1;
      if (r_iter == 4'd15) r_busy <= 1'b0;
    end
  end

  // The final iteration result is taken combinationally so no extra cycle is spent.
  assign o_busy      = r_busy;
  assign o_valid     = r_busy && (r_iter == 4'd15);
  assign o_root      = w_root_nxt;
  assign o_remainder = w_rem_nxt;

endmodule

// File: rtl/amplitude_estimator.sv
// Reconstructs |00>..|11> amplitude magnitudes from 2^LOG2_SHOTS measurement
// outcomes as sqrt(count/SHOTS) in Q1.15. AMP_ROUND_EN selects round-to-nearest.
module amplitude_estimator
  import qstate_pkg::*;
#(
  parameter int LOG2_SHOTS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    shot_valid,
  input  logic [1:0]              shot,
  output logic                    shot_ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [AMP_W-1:0] amp00_real,
  output logic signed [AMP_W-1:0] amp01_real,
  output logic signed [AMP_W-1:0] amp10_real,
  output logic signed [AMP_W-1:0] amp11_real,
  output logic [1:0]              dbg_state
);

  localparam int CW = LOG2_SHOTS + 1;
  localparam logic [CW-1:0] SHOTS_M1 = CW'((1 << LOG2_SHOTS) - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt [4];
  logic [CW-1:0]    r_seen;
  logic [1:0]       r_basis;
  logic [4:0]       r_step;
  logic [AMP_W-1:0] r_hold [3];
  logic [AMP_W-1:0] r_amp [4];

  logic             w_accept;
  logic             w_load;
  logic [30:0]      w_rad;
  logic             w_sq_busy;
  logic             w_sq_valid;
  logic [15:0]      w_sq_root;
  logic [16:0]      w_sq_rem;
  logic [AMP_W:0]   w_root_rnd;
  logic [AMP_W-1:0] w_amp;

  assign w_accept = shot_valid && (r_state == ACCUM);
  assign w_load   = (r_state == SQRT) && (r_step == 5'd0) && !w_sq_busy;
  // count/SHOTS scaled to Q2.30 so the root lands directly in Q1.15.
  assign w_rad    = 31'(r_cnt[r_basis]) << (30 - LOG2_SHOTS);

  isqrt_serial u_isqrt (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_radicand  (w_rad),
    .o_busy      (w_sq_busy),
    .o_valid     (w_sq_valid),
    .o_root      (w_sq_root),
    .o_remainder (w_sq_rem)
  );

`ifdef AMP_ROUND_EN
  assign w_root_rnd = {1'b0, w_sq_root} + (AMP_W+1)'(w_sq_rem > {1'b0, w_sq_root});
`else
  logic w_rem_unused;
  assign w_rem_unused = ^w_sq_rem;
  assign w_root_rnd   = {1'b0, w_sq_root};
`endif

  assign w_amp = sat_amp(w_root_rnd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_seen  <= '0;
      r_basis <= '0;
      r_step  <= '0;
      for (int b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
        r_amp[b] <= '0;
      end
      for (int b = 0; b < 3; b++) r_hold[b] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
            r_seen  <= '0;
            r_basis <= '0;
            r_step  <= '0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_cnt[shot] <= r_cnt[shot] + 1'b1;
            r_seen      <= r_seen + 1'b1;
            if (r_seen == SHOTS_M1) r_state <= SQRT;
          end
        end
        SQRT: begin
          if (w_sq_valid) begin
            case (r_basis)
              BASIS_00: r_hold[0] <= w_amp;
              BASIS_01: r_hold[1] <= w_amp;
              BASIS_10: r_hold[2] <= w_amp;
              default: begin
                // Last basis: publish all four together so no partial estimate leaks out.
                r_amp[0] <= r_hold[0];
                r_amp[1] <= r_hold[1];
                r_amp[2] <= r_hold[2];
                r_amp[3] <= w_amp;
              end
            endcase
          end
          if (r_step == 5'd16) begin
            r_step <= '0;
            if (r_basis == BASIS_11) r_state <= DONE;
            else r_basis <= r_basis + 2'd1;
          end else begin
            r_step <= r_step + 5'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign shot_ready = (r_state == ACCUM);
  assign busy       = (r_state == ACCUM) || (r_state == SQRT);
  assign done       = (r_state == DONE);
  assign amp00_real = r_amp[0];
  assign amp01_real = r_amp[1];
  assign amp10_real = r_amp[2];
  assign amp11_real = r_amp[3];
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_amplitude_estimator.sv
// Bench for amplitude_estimator: constant-vector table, hand sequences for
// abort/ignored-start corners, and random runs against a sqrt reference model.
module tb_amplitude_estimator;
  import qstate_pkg::*;

  localparam int LOG2_SHOTS = 8;
  localparam int SHOTS      = 1 << LOG2_SHOTS;
`ifdef AMP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef logic [3:0][15:0] quad_t;
  typedef struct {
    quad_t c;
    quad_t e;
    bit    gaps;
    int    start_at;
    bit    start_in_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic shot_valid = 1'b0;
  logic [1:0] shot = 2'd0;
  logic shot_ready, busy, done;
  logic signed [15:0] amp00_real, amp01_real, amp10_real, amp11_real;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_amps = '0;
  vec_t tbl[6];

  amplitude_estimator #(.LOG2_SHOTS(LOG2_SHOTS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .shot_valid (shot_valid),
    .shot       (shot),
    .shot_ready (shot_ready),
    .busy       (busy),
    .done       (done),
    .amp00_real (amp00_real),
    .amp01_real (amp01_real),
    .amp10_real (amp10_real),
    .amp11_real (amp11_real),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic quad_t mk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // reference: round-or-floor of sqrt(count/SHOTS) * 2^15, clipped to 32767
  function automatic logic [15:0] model_amp(input int count);
    longint x, r;
    x = longint'(count) << (30 - LOG2_SHOTS);
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    if (RND && (x - r * r > r)) r++;
    if (r > 32767) r = 32767;
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] amps_now();
    return {amp11_real, amp10_real, amp01_real, amp00_real};
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_shots(input quad_t c, input bit gaps, input int start_at,
                            output int last_cyc);
    logic [1:0] q[$];
    logic [1:0] tmp;
    int j, t;
    last_cyc = 0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < int'(c[b]); k++) q.push_back(2'(b));
    for (int i = q.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) begin
        t = $urandom_range(2, 0);
        repeat (t) begin @(negedge clk); shot_valid = 1'b0; start = 1'b0; end
      end
      @(negedge clk);
      shot_valid = 1'b1;
      shot = q[i];
      start = (i == start_at);
      t = 0;
      while (!shot_ready && t < 50) begin @(negedge clk); start = 1'b0; t++; end
      if (!shot_ready) begin
        chk("shot_ready_timeout", 0, 1);
        shot_valid = 1'b0;
        start = 1'b0;
        return;
      end
      last_cyc = cyc;
    end
    // keep offering a shot after the last accept: it must be refused
    @(negedge clk);
    start = 1'b0;
    shot = 2'd3;
    chk("busy_after_last_shot", busy, 1);
    for (int k = 0; k < 3; k++) begin
      chk("ready_low_after_last_shot", shot_ready, 0);
      @(negedge clk);
    end
    shot_valid = 1'b0;
  endtask

  task automatic wait_done(input int last_cyc, input bit start_in_done);
    int t;
    logic [63:0] e;
    t = 0;
    while (!done && t < 300) begin @(negedge clk); t++; end
    if (!done) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_latency", 64'(cyc - last_cyc), 69);
    chk("busy_in_done", busy, 0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("amp00", 64'(amp00_real), 64'(e[15:0]));
    chk("amp01", 64'(amp01_real), 64'(e[31:16]));
    chk("amp10", 64'(amp10_real), 64'(e[47:32]));
    chk("amp11", 64'(amp11_real), 64'(e[63:48]));
    last_amps = e;
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_single_cycle", done, 0);
    chk("idle_after_done", dbg_state, IDLE);
    @(negedge clk);
    chk("still_idle", dbg_state, IDLE);
    chk("amps_hold", amps_now(), e);
  endtask

  task automatic run_vec(input quad_t c, input quad_t e, input bit gaps,
                         input int start_at, input bit start_in_done);
    int last;
    exp_q.push_back(e);
    start_pulse();
    send_shots(c, gaps, start_at, last);
    wait_done(last, start_in_done);
  endtask

  initial begin
    int last, t, seen;
    quad_t c, e;
    logic [1:0] b;

    tbl[0] = '{c: mk(256, 0, 0, 0),   e: mk(32767, 0, 0, 0),         gaps: 0, start_at: -1,  start_in_done: 0};
    tbl[1] = '{c: mk(128, 128, 0, 0), e: mk(23170, 23170, 0, 0),     gaps: 0, start_at: -1,  start_in_done: 0};
    tbl[2] = '{c: mk(64, 64, 64, 64), e: mk(16384, 16384, 16384, 16384), gaps: 1, start_at: -1, start_in_done: 0};
    tbl[3] = '{c: mk(255, 0, 0, 1),   e: mk(RND ? 32704 : 32703, 0, 0, 2048), gaps: 0, start_at: -1, start_in_done: 0};
    tbl[4] = '{c: mk(192, 64, 0, 0),  e: mk(RND ? 28378 : 28377, 16384, 0, 0), gaps: 1, start_at: 100, start_in_done: 1};
    tbl[5] = '{c: mk(0, 0, 0, 256),   e: mk(0, 0, 0, 32767),         gaps: 0, start_at: -1,  start_in_done: 0};

    do_reset();
    @(negedge clk);
    chk("reset_state", dbg_state, IDLE);
    chk("reset_ready", shot_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_amps", amps_now(), 0);

    // shots offered in IDLE must be refused and not counted
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      shot_valid = 1'b1;
      shot = 2'd3;
      chk("idle_ready_low", shot_ready, 0);
    end
    @(negedge clk);
    shot_valid = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i].c, tbl[i].e, tbl[i].gaps, tbl[i].start_at, tbl[i].start_in_done);

    // abort in the middle of the square-root phase
    start_pulse();
    send_shots(mk(0, 256, 0, 0), 0, -1, last);
    t = 0;
    while (cyc < last + 30 && t < 100) begin @(negedge clk); t++; end
    chk("sqrt_busy_mid", busy, 1);
    chk("no_partial_amps", amps_now(), last_amps);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_amps", amps_now(), 0);
    last_amps = '0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    run_vec(mk(0, 0, 256, 0), mk(0, 0, 32767, 0), 0, -1, 0);

    // random distributions against the model
    for (int r = 0; r < 5; r++) begin
      c = '0;
      t = $urandom_range(2, 0);
      for (int k = 0; k < SHOTS; k++) begin
        if (t == 0) b = 2'($urandom_range(3, 0));
        else if (t == 1) b = ($urandom_range(9, 0) < 8) ? 2'd0 : 2'($urandom_range(3, 1));
        else b = 2'($urandom_range(1, 0));
        c[b] = c[b] + 16'd1;
      end
      for (int k = 0; k < 4; k++) e[k] = model_amp(int'(c[k]));
      run_vec(c, e, 1'($urandom_range(1, 0)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
